// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path and its scan-code decoder.
package ps2_pkg;

  // Receiver frame-tracking states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Payload bits carried by one PS/2 frame
  localparam int FRAME_DATA_BITS = 8;

  // Scan-code prefixes interpreted by the downstream decoder
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one asynchronous PS/2 line and removes short glitches.
// The fall output is a single-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             filtered;
  logic [CNT_W-1:0] run_cnt;

  // Two-stage synchroniser, then flip the filtered level only after
  // FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= 1'b1;
      sync_p1  <= 1'b1;
      filtered <= 1'b1;
      run_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      sync_p0 <= line;
      sync_p1 <= sync_p0;
      fall    <= 1'b0;
      if (sync_p1 != filtered) begin
        if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
          filtered <= sync_p1;
          run_cnt  <= '0;
          fall     <= ~sync_p1;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit device frames into scan codes.
// A valid byte updates scan_code and, one cycle later, pulses scan_ready;
// parity, stop or timeout failures pulse frame_error instead.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_ready,
  output logic       frame_error
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int BIT_W = $clog2(FRAME_DATA_BITS);

  logic                       clk_fall;
  logic                       data_p0;
  logic                       data_p1;
  state_t                     state;
  logic [FRAME_DATA_BITS-1:0] shreg;
  logic                       parity_bit;
  logic [BIT_W-1:0]           bit_cnt;
  logic [TO_W-1:0]            to_cnt;
  logic                       timeout;
  logic                       ok_p0;
  logic                       err_p0;

  // Odd parity over data+parity and a high stop bit make a good frame
  function automatic logic frame_valid(input logic [FRAME_DATA_BITS-1:0] d,
                                       input logic p, input logic stop_bit);
    return stop_bit & (^{d, p});
  endfunction

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk),
    .reset(reset),
    .line (ps2_clk),
    .fall (clk_fall)
  );

  // Plain two-stage synchroniser for the data pin; its delay matches the
  // clock synchroniser and the data is stable long before each fall strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      data_p0 <= ps2_data;
      data_p1 <= data_p0;
    end
  end

  // A fall strobe always wins over an expiring timeout in the same cycle
  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !clk_fall;

  // Capture payload and parity bits; datapath only, qualified by the FSM
  always_ff @(posedge clk) begin
    if (clk_fall && state == DATA) begin
      shreg <= {data_p1, shreg[FRAME_DATA_BITS-1:1]};
    end
    if (clk_fall && state == PARITY) begin
      parity_bit <= data_p1;
    end
  end

  // Frame FSM, timeout counter and registered result pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      scan_code   <= 8'h00;
      ok_p0       <= 1'b0;
      err_p0      <= 1'b0;
      scan_ready  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      // result stage: scan_code settles one cycle before scan_ready rises
      scan_ready  <= ok_p0;
      frame_error <= err_p0;
      ok_p0       <= 1'b0;
      err_p0      <= 1'b0;

      if (clk_fall || state == IDLE) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (clk_fall && !data_p1) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (clk_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(FRAME_DATA_BITS - 1)) begin
              state <= PARITY;
            end
          end else if (timeout) begin
            state  <= IDLE;
            err_p0 <= 1'b1;
          end
        end
        PARITY: begin
          if (clk_fall) begin
            state <= STOP;
          end else if (timeout) begin
            state  <= IDLE;
            err_p0 <= 1'b1;
          end
        end
        STOP: begin
          if (clk_fall) begin
            state <= IDLE;
            if (frame_valid(shreg, parity_bit, data_p1)) begin
              scan_code <= shreg;
              ok_p0     <= 1'b1;
            end else begin
              err_p0 <= 1'b1;
            end
          end else if (timeout) begin
            state  <= IDLE;
            err_p0 <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frames are driven on the pins, the expected
// outcome of each is queued, and every output pulse is popped and compared.
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 200;
  localparam int HALF       = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       frame_error;

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic       chk_lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_stop_cyc = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] code_q = 8'h00;
  logic       chg_pend = 1'b0;
  logic       rdy_q = 1'b0;
  logic       err_q = 1'b0;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_ready (scan_ready),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor, sampled 1 ns after the active edge
  always @(posedge clk) begin
    #1;
    if (reset) begin
      code_q    = scan_code;
      last_good = 8'h00;
      chg_pend  = 1'b0;
      rdy_q     = 1'b0;
      err_q     = 1'b0;
    end else begin
      if (chg_pend) check("ready_after_code", {31'd0, scan_ready}, 32'd1);
      chg_pend = (scan_code != code_q);
      code_q   = scan_code;
      if (rdy_q) check("ready_width", {31'd0, scan_ready}, 32'd0);
      if (err_q) check("error_width", {31'd0, frame_error}, 32'd0);
      if ((scan_ready && !rdy_q) || (frame_error && !err_q)) begin
        if (sb.size() == 0) begin
          check("spurious_pulse", {30'd0, scan_ready, frame_error}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_kind", {30'd0, scan_ready, frame_error},
                e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) begin
            check("scan_code", {24'd0, scan_code}, {24'd0, e.code});
            last_good = e.code;
          end else begin
            check("code_hold", {24'd0, scan_code}, {24'd0, last_good});
          end
          if (e.chk_lat) check("latency", cyc - last_stop_cyc, FILTER_LEN + 4);
        end
      end
      rdy_q = scan_ready;
      err_q = frame_error;
    end
  end

  task automatic send_bit(input logic b, input logic glitch, input logic is_stop);
    ps2_data = b;
    if (glitch) begin
      repeat (8) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF - 8 - (FILTER_LEN - 1)) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b0;
    if (is_stop) last_stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic stop_b, input logic glitch);
    exp_t e;
    logic par;
    par       = (~^d) ^ bad_par;
    e.is_err  = bad_par | ~stop_b;
    e.code    = d;
    e.chk_lat = 1'b1;
    sb.push_back(e);
    send_bit(1'b0, glitch, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch, 1'b0);
    send_bit(par, glitch, 1'b0);
    send_bit(stop_b, glitch, 1'b1);
    ps2_data = 1'b1;
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(1'b1, 1'b0, 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t te;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_code", {24'd0, scan_code}, 32'd0);
    check("rst_ready", {31'd0, scan_ready}, 32'd0);
    check("rst_error", {31'd0, frame_error}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // valid single frame
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain(200);

    // back-to-back frames
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain(200);

    // bad parity, then bad stop bit
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    wait_drain(200);
    send_frame(8'h58, 1'b0, 1'b0, 1'b0);
    wait_drain(200);
    check("code_after_errors", {24'd0, scan_code}, 32'h1C);

    // partial frame abandoned until timeout, then a good frame
    te.is_err  = 1'b1;
    te.code    = 8'h00;
    te.chk_lat = 1'b0;
    sb.push_back(te);
    send_partial(5);
    repeat (TIMEOUT + 10) @(negedge clk);
    wait_drain(100);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    wait_drain(200);

    // sub-threshold clock glitches on every bit
    send_frame(8'h29, 1'b0, 1'b1, 1'b1);
    wait_drain(200);

    // reset in the middle of a frame
    send_partial(4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midreset_code", {24'd0, scan_code}, 32'd0);
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    wait_drain(200);

    repeat (TIMEOUT + 20) @(negedge clk);
    check("no_leftover", sb.size(), 0);
    check("final_code", {24'd0, scan_code}, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
